// File: rtl/rotate_pkg.sv
// Shared types and default sizes for the rotated-frame scheduler.
package rotate_pkg;

    localparam int DEFAULT_PIXEL_WIDTH = 16;
    localparam int DEFAULT_IMAGE_SIZE  = 64;
    localparam int DEFAULT_COOR_WIDTH  = 6;

    typedef enum logic [2:0] {
        IDLE,
        ROT_START,
        ROT_WAIT,
        MEM_REQ,
        MEM_WAIT,
        OUT,
        DONE
    } rot_sched_state_t;

endpackage

// File: rtl/raster_scan_counter.sv
// Destination-pixel raster counter: H runs fastest, V saturates on the last row.
module raster_scan_counter
    import rotate_pkg::*;
#(
    parameter int IMAGE_SIZE = DEFAULT_IMAGE_SIZE,
    parameter int COOR_WIDTH = DEFAULT_COOR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_advance,
    output logic [COOR_WIDTH-1:0] o_H,
    output logic [COOR_WIDTH-1:0] o_V,
    output logic                  o_last
);

    localparam logic [COOR_WIDTH-1:0] MAX_C = COOR_WIDTH'(IMAGE_SIZE - 1);

    logic [COOR_WIDTH-1:0] r_H;
    logic [COOR_WIDTH-1:0] r_V;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_H <= '0;
            r_V <= '0;
        end else if (i_advance) begin
            if (r_H == MAX_C) begin
                r_H <= '0;
                if (r_V != MAX_C) begin
                    r_V <= r_V + 1'b1;
                end
            end else begin
                r_H <= r_H + 1'b1;
            end
        end
    end

    assign o_H    = r_H;
    assign o_V    = r_V;
    assign o_last = (r_H == MAX_C) && (r_V == MAX_C);

endmodule

// File: rtl/rotate_frame_scheduler.sv
// Walks every destination pixel, asks the rotator for its source coordinate,
// fetches it from SRAM (or substitutes the background) and streams it out.
module rotate_frame_scheduler
    import rotate_pkg::*;
#(
    parameter int                     IMAGE_SIZE  = DEFAULT_IMAGE_SIZE,
    parameter int                     COOR_WIDTH  = DEFAULT_COOR_WIDTH,
    parameter int                     ANG_WIDTH   = 9,
    parameter int                     PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
    parameter int                     ADDR_WIDTH  = 2 * COOR_WIDTH,
    parameter logic [PIXEL_WIDTH-1:0] BG_PIXEL    = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic signed [ANG_WIDTH-1:0] i_angle,
    input  logic                        i_abort,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_rot_start,
    output logic [COOR_WIDTH-1:0]       o_rot_H,
    output logic [COOR_WIDTH-1:0]       o_rot_V,
    output logic signed [ANG_WIDTH-1:0] o_rot_angle,
    input  logic                        i_rot_valid,
    input  logic [COOR_WIDTH-1:0]       i_rot_H,
    input  logic [COOR_WIDTH-1:0]       i_rot_V,
    input  logic                        i_rot_oor,
    output logic                        o_mem_req,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    input  logic                        i_mem_ack,
    input  logic [PIXEL_WIDTH-1:0]      i_mem_data,
    output logic                        o_pix_valid,
    output logic [PIXEL_WIDTH-1:0]      o_pix_data,
    output logic                        o_pix_last,
    input  logic                        i_pix_ready
);

    rot_sched_state_t r_state;
    rot_sched_state_t w_next;

    logic signed [ANG_WIDTH-1:0] r_angle;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic [PIXEL_WIDTH-1:0]      r_pix;
    logic [COOR_WIDTH-1:0]       w_H;
    logic [COOR_WIDTH-1:0]       w_V;
    logic                        w_last;
    logic                        w_accept;
    logic                        w_rot_take;
    logic                        w_mem_take;
    logic                        w_pix_fire;

    assign w_accept   = (r_state == IDLE) && i_start;
    assign w_rot_take = (r_state == ROT_WAIT) && i_rot_valid;
    assign w_mem_take = o_mem_req && i_mem_ack;
    assign w_pix_fire = (r_state == OUT) && i_pix_ready;

    // A power-of-two frame side lets the address be a plain concatenation.
    generate
        if (IMAGE_SIZE == 2 ** COOR_WIDTH) begin : g_pow2
            assign w_addr = ADDR_WIDTH'({i_rot_V, i_rot_H});
        end else begin : g_mul
            assign w_addr = ADDR_WIDTH'(i_rot_V) * ADDR_WIDTH'(IMAGE_SIZE)
                          + ADDR_WIDTH'(i_rot_H);
        end
    endgenerate

    raster_scan_counter #(
        .IMAGE_SIZE (IMAGE_SIZE),
        .COOR_WIDTH (COOR_WIDTH)
    ) u_scan (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_accept || i_abort),
        .i_advance (w_pix_fire && !i_abort),
        .o_H       (w_H),
        .o_V       (w_V),
        .o_last    (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_rot_start = 1'b0;
        o_mem_req   = 1'b0;
        o_pix_valid = 1'b0;
        o_pix_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next = ROT_START;
            end
            ROT_START: begin
                o_busy      = 1'b1;
                o_rot_start = 1'b1;
                w_next      = ROT_WAIT;
            end
            ROT_WAIT: begin
                o_busy = 1'b1;
                if (i_rot_valid) w_next = i_rot_oor ? OUT : MEM_REQ;
            end
            MEM_REQ: begin
                o_busy    = 1'b1;
                o_mem_req = 1'b1;
                w_next    = i_mem_ack ? OUT : MEM_WAIT;
            end
            MEM_WAIT: begin
                o_busy    = 1'b1;
                o_mem_req = 1'b1;
                if (i_mem_ack) w_next = OUT;
            end
            OUT: begin
                o_busy      = 1'b1;
                o_pix_valid = 1'b1;
                o_pix_last  = w_last;
                if (i_pix_ready) w_next = w_last ? DONE : ROT_START;
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (i_abort) w_next = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort) begin
            r_angle <= '0;
            r_addr  <= '0;
            r_pix   <= '0;
        end else begin
            if (w_accept) r_angle <= i_angle;
            if (w_rot_take) begin
                if (i_rot_oor) r_pix <= BG_PIXEL;
                else           r_addr <= w_addr;
            end
            if (w_mem_take) r_pix <= i_mem_data;
        end
    end

    assign o_rot_H     = w_H;
    assign o_rot_V     = w_V;
    assign o_rot_angle = r_angle;
    assign o_mem_addr  = r_addr;
    assign o_pix_data  = r_pix;

endmodule

// File: tb/tb_rotate_frame_scheduler.sv
// Directed bench: 4x4 frame, identity rotator with 3-cycle latency,
// SRAM model that returns its address as data after a programmable delay.
module tb_rotate_frame_scheduler;

    localparam int N   = 4;
    localparam int CW  = 2;
    localparam int AW  = 9;
    localparam int PW  = 16;
    localparam int ADW = 4;
    localparam logic [PW-1:0] BG = 16'hABCD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort_i = 1'b0;
    logic                 ready = 1'b1;
    logic signed [AW-1:0] angle = '0;

    logic                 o_busy, o_done, o_rot_start;
    logic [CW-1:0]        o_rot_H, o_rot_V;
    logic signed [AW-1:0] o_rot_angle;
    logic                 o_mem_req, o_pix_valid, o_pix_last;
    logic [ADW-1:0]       o_mem_addr;
    logic [PW-1:0]        o_pix_data;

    logic [2:0]    r_sh = '0;
    logic [CW-1:0] r_rh = '0;
    logic [CW-1:0] r_rv = '0;
    logic          r_ack = 1'b0;
    logic [PW-1:0] r_md = '0;
    int            wcnt = 0;
    int            mem_delay = 0;
    logic          oor_mode = 1'b0;

    int n_rs = 0, n_req = 0, n_done = 0;
    int tests = 0, fails = 0;

    rotate_frame_scheduler #(
        .IMAGE_SIZE (N), .COOR_WIDTH (CW), .ANG_WIDTH (AW),
        .PIXEL_WIDTH (PW), .ADDR_WIDTH (ADW), .BG_PIXEL (BG)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_start (start), .i_angle (angle),
        .i_abort (abort_i), .o_busy (o_busy), .o_done (o_done),
        .o_rot_start (o_rot_start), .o_rot_H (o_rot_H), .o_rot_V (o_rot_V),
        .o_rot_angle (o_rot_angle), .i_rot_valid (r_sh[2]),
        .i_rot_H (r_rh), .i_rot_V (r_rv),
        .i_rot_oor (oor_mode && (r_rv == '0)),
        .o_mem_req (o_mem_req), .o_mem_addr (o_mem_addr),
        .i_mem_ack (r_ack), .i_mem_data (r_md),
        .o_pix_valid (o_pix_valid), .o_pix_data (o_pix_data),
        .o_pix_last (o_pix_last), .i_pix_ready (ready)
    );

    // Identity rotator, valid three cycles after the start pulse.
    always @(posedge clk) begin
        if (rst || abort_i) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[1:0], o_rot_start};
            if (o_rot_start) begin
                r_rh <= o_rot_H;
                r_rv <= o_rot_V;
            end
        end
    end

    always @(posedge clk) begin
        if (rst || abort_i || r_ack) begin
            r_ack <= 1'b0;
            wcnt  <= 0;
        end else if (o_mem_req) begin
            if (wcnt == mem_delay) begin
                r_ack <= 1'b1;
                r_md  <= PW'(o_mem_addr);
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (o_rot_start) n_rs <= n_rs + 1;
        if (o_mem_req)   n_req <= n_req + 1;
        if (o_done)      n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic get_pix(output logic [PW-1:0] d, output logic l,
                           output int n);
        d = '0;
        l = 1'b0;
        n = 0;
        repeat (200) begin
            @(negedge clk);
            n++;
            if (o_pix_valid && ready) begin
                d = o_pix_data;
                l = o_pix_last;
                return;
            end
        end
        n = -1;
    endtask

    task automatic scan(input int first, input int last_idx,
                        input bit use_bg, input int exp_lat);
        logic [PW-1:0] d;
        logic          l;
        int            n;
        for (int i = first; i <= last_idx; i++) begin
            get_pix(d, l, n);
            chk($sformatf("pix%0d_seen", i), 32'(n > 0), 32'd1);
            chk($sformatf("pix%0d_data", i), 32'(d),
                (use_bg && i < N) ? 32'(BG) : 32'(i));
            chk($sformatf("pix%0d_last", i), 32'(l), 32'(i == N * N - 1));
            if (i == 1 && exp_lat != 0)
                chk("pix_latency", 32'(n), 32'(exp_lat));
        end
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_done_busy"}, 32'(o_busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_len"}, 32'(o_done), 32'd0);
    endtask

    task automatic pulse_start(input logic signed [AW-1:0] a);
        angle = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!o_mem_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_seen", 32'(o_mem_req), 32'd1);
    endtask

    logic [PW-1:0]  d0;
    logic [ADW-1:0] a0;
    int             n, r0, rs0, dn0;
    bit             stable;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({o_busy, o_done, o_rot_start, o_mem_req,
                            o_pix_valid, o_pix_last}), 32'd0);
        chk("rst_data", 32'({o_rot_H, o_rot_V, o_mem_addr, o_pix_data}), 32'd0);
        chk("rst_angle", 32'(o_rot_angle), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Identity frame, zero-wait SRAM
        dn0 = n_done;
        pulse_start(9'sd0);
        chk("s1_busy", 32'(o_busy), 32'd1);
        chk("s1_rot_start", 32'(o_rot_start), 32'd1);
        chk("s1_HV", 32'({o_rot_H, o_rot_V}), 32'd0);
        scan(0, 15, 1'b0, 7);
        start = 1'b1;
        @(negedge clk);
        chk("s1_done", 32'(o_done), 32'd1);
        chk("s1_done_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("s1_start_in_done", 32'(o_busy), 32'd0);
        chk("s1_done_count", 32'(n_done - dn0), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("s1_start_after_done", 32'(o_busy), 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("s1_abort_busy", 32'(o_busy), 32'd0);

        // Top row out of range
        oor_mode = 1'b1;
        r0 = n_req;
        pulse_start(9'sd0);
        scan(0, 3, 1'b1, 5);
        chk("s2_no_req", 32'(n_req - r0), 32'd0);
        scan(4, 15, 1'b1, 0);
        chk("s2_req_cycles", 32'(n_req - r0), 32'd24);
        expect_done("s2");
        oor_mode = 1'b0;

        // Downstream stall on pixel 7
        pulse_start(9'sd0);
        scan(0, 6, 1'b0, 7);
        @(negedge clk);
        ready = 1'b0;
        n = 0;
        while (!o_pix_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("s3_valid", 32'(o_pix_valid), 32'd1);
        d0 = o_pix_data;
        rs0 = n_rs;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(o_pix_valid && o_pix_data == d0)) stable = 1'b0;
        end
        chk("s3_stable", 32'(stable), 32'd1);
        chk("s3_data", 32'(d0), 32'd7);
        chk("s3_no_rot_start", 32'(n_rs - rs0), 32'd0);
        ready = 1'b1;
        scan(8, 15, 1'b0, 0);
        expect_done("s3");

        // Slow SRAM
        mem_delay = 4;
        pulse_start(9'sd0);
        scan(0, 4, 1'b0, 0);
        wait_req();
        a0 = o_mem_addr;
        stable = 1'b1;
        n = 0;
        while (!r_ack && n < 20) begin
            if (!(o_mem_req && o_mem_addr == a0)) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("s4_addr", 32'(a0), 32'd5);
        chk("s4_hold", 32'(stable), 32'd1);
        chk("s4_wait", 32'(n), 32'd5);
        chk("s4_req_at_ack", 32'(o_mem_req), 32'd1);
        scan(5, 15, 1'b0, 0);
        expect_done("s4");
        mem_delay = 0;

        // Abort in ROT_WAIT of pixel 5, then restart at 90 degrees
        pulse_start(9'sd0);
        scan(0, 4, 1'b0, 0);
        @(negedge clk);
        chk("s5_rot_start", 32'(o_rot_start), 32'd1);
        chk("s5_HV", 32'({o_rot_H, o_rot_V}), 32'h5);
        @(negedge clk);
        dn0 = n_done;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("s5_busy", 32'(o_busy), 32'd0);
        chk("s5_outs", 32'({o_rot_start, o_mem_req, o_pix_valid,
                            o_rot_H, o_rot_V}), 32'd0);
        repeat (6) @(negedge clk);
        chk("s5_no_done", 32'(n_done - dn0), 32'd0);
        pulse_start(9'sd90);
        chk("s5_restart_rs", 32'(o_rot_start), 32'd1);
        chk("s5_restart_HV", 32'({o_rot_H, o_rot_V}), 32'd0);
        chk("s5_angle", 32'(o_rot_angle), 32'd90);
        scan(0, 15, 1'b0, 7);
        expect_done("s5");

        // Start while busy, then reset inside MEM_WAIT
        pulse_start(9'sd0);
        scan(0, 1, 1'b0, 7);
        @(negedge clk);
        @(negedge clk);
        pulse_start(9'sd45);
        angle = '0;
        chk("s6_angle", 32'(o_rot_angle), 32'd0);
        chk("s6_busy", 32'(o_busy), 32'd1);
        chk("s6_H", 32'(o_rot_H), 32'd2);
        mem_delay = 4;
        wait_req();
        @(negedge clk);
        chk("s6_memwait", 32'(o_mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_rst_ctl", 32'({o_busy, o_done, o_rot_start, o_mem_req,
                               o_pix_valid, o_pix_last}), 32'd0);
        chk("s6_rst_data", 32'({o_rot_H, o_rot_V, o_mem_addr, o_pix_data}), 32'd0);
        chk("s6_rst_angle", 32'(o_rot_angle), 32'd0);
        mem_delay = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
